// File: rtl/counter_pkg.sv
// counter_pkg: shared types and default sizes for the counter stream checker
package counter_pkg;
  typedef enum logic [1:0] {UNSYNC, SYNC, LOCKED} state_t;
  localparam int WIDTH_DEF = 32;
  localparam int SYNC_DEF  = 4;
  localparam int ERR_W_DEF = 16;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter that sticks at all-ones, with sync clear
//  clk  in  clock
//  rst  in  asynchronous active-low reset
//  clr  in  synchronous clear (wins over inc)
//  inc  in  count enable
//  q    out current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (clr) q <= '0;
    else if (inc && q != '1) q <= q + W'(1);
endmodule

// File: rtl/counter_checker.sv
// counter_checker: locks onto an incrementing counter stream and flags broken steps
//  clk        in  clock, all sampling on posedge
//  rst        in  asynchronous active-low reset
//  d_in       in  observed counter value
//  locked     out stream tracked, checking active
//  err_pulse  out one-cycle pulse on a mismatch while locked
//  rst_seen   out one-cycle pulse on a counter restart (d_in==0) while locked
//  err_count  out saturating count of err_pulse events
//  last_bad   out value that caused the most recent err_pulse
//  expected   out value expected on the next sample, valid when locked
module counter_checker
  import counter_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int SYNC_COUNT = SYNC_DEF,
  parameter int ERR_W      = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  output logic             locked,
  output logic             err_pulse,
  output logic             rst_seen,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] last_bad,
  output logic [WIDTH-1:0] expected
);
  localparam int RUN_W = $clog2(SYNC_COUNT + 1);
  state_t state, state_d;
  logic [WIDTH-1:0] prev, prev_d, nxt, last_bad_d, expected_d;
  logic [RUN_W-1:0] run;
  logic run_inc, run_clr, err, rs, lock_d;
  assign nxt = prev + WIDTH'(1);
  sat_counter #(.W(RUN_W)) u_run (
    .clk(clk), .rst(rst), .clr(run_clr), .inc(run_inc), .q(run)
  );
  sat_counter #(.W(ERR_W)) u_err (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(err), .q(err_count)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= UNSYNC;
      prev  <= '0;
    end else begin
      state <= state_d;
      prev  <= prev_d;
    end
  // An X/Z sample makes the equality unknown, which falls into the mismatch branches.
  always_comb begin
    state_d    = state;
    prev_d     = d_in;
    run_inc    = 1'b0;
    run_clr    = 1'b0;
    err        = 1'b0;
    rs         = 1'b0;
    lock_d     = 1'b0;
    expected_d = expected;
    last_bad_d = last_bad;
    case (state)
      UNSYNC: begin
        run_clr = 1'b1;
        state_d = SYNC;
      end
      SYNC: begin
        if (d_in == nxt) begin
          run_inc = 1'b1;
          if (run == RUN_W'(SYNC_COUNT - 1)) begin
            state_d    = LOCKED;
            lock_d     = 1'b1;
            expected_d = d_in + WIDTH'(1);
          end
        end else begin
          run_clr = 1'b1;
        end
      end
      LOCKED: begin
        lock_d = 1'b1;
        if (d_in == expected) begin
          expected_d = d_in + WIDTH'(1);
        end else if (d_in == '0 && expected != '0) begin
          rs      = 1'b1;
          lock_d  = 1'b0;
          run_clr = 1'b1;
          state_d = SYNC;
        end else begin
          err        = 1'b1;
          last_bad_d = d_in;
          lock_d     = 1'b0;
          run_clr    = 1'b1;
          state_d    = SYNC;
        end
      end
      default: state_d = UNSYNC;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      rst_seen  <= 1'b0;
      last_bad  <= '0;
      expected  <= '0;
    end else begin
      locked    <= lock_d;
      err_pulse <= err;
      rst_seen  <= rs;
      last_bad  <= last_bad_d;
      expected  <= expected_d;
    end
endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: vector table, reset corner cases and randomized model check
module tb_counter_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] d_in = '0;
  logic        a_locked, a_err_pulse, a_rst_seen;
  logic [15:0] a_err_count;
  logic [31:0] a_last_bad, a_expected;
  logic        b_locked, b_err_pulse, b_rst_seen;
  logic [1:0]  b_err_count;
  logic [31:0] b_last_bad, b_expected;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  counter_checker #(.WIDTH(32), .SYNC_COUNT(4), .ERR_W(16)) u_a (
    .clk(clk), .rst(rst), .d_in(d_in), .locked(a_locked), .err_pulse(a_err_pulse),
    .rst_seen(a_rst_seen), .err_count(a_err_count), .last_bad(a_last_bad), .expected(a_expected)
  );
  counter_checker #(.WIDTH(32), .SYNC_COUNT(4), .ERR_W(2)) u_b (
    .clk(clk), .rst(rst), .d_in(d_in), .locked(b_locked), .err_pulse(b_err_pulse),
    .rst_seen(b_rst_seen), .err_count(b_err_count), .last_bad(b_last_bad), .expected(b_expected)
  );
  typedef struct {
    logic [31:0] d;
    bit          l, ep, rs;
    int          cnt;
    logic [31:0] bad, ex;
  } vec_t;
  vec_t tbl[$];
  task automatic add(input logic [31:0] d, input bit l, ep, rs, input int cnt, input logic [31:0] bad, ex);
    vec_t v;
    v.d = d; v.l = l; v.ep = ep; v.rs = rs; v.cnt = cnt; v.bad = bad; v.ex = ex;
    tbl.push_back(v);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask
  task automatic check_all(input bit l, ep, rs, input int cnt, input logic [31:0] bad, ex, input bit use_ex);
    chk("locked", a_locked, l);
    chk("err_pulse", a_err_pulse, ep);
    chk("rst_seen", a_rst_seen, rs);
    chk("err_count", a_err_count, cnt);
    chk("last_bad", a_last_bad, bad);
    if (use_ex) chk("expected", a_expected, ex);
    chk("b_locked", b_locked, l);
    chk("b_err_count_sat", b_err_count, cnt > 3 ? 3 : cnt);
    chk("pulse_excl", a_err_pulse & a_rst_seen, 0);
  endtask
  task automatic step(input logic [31:0] d);
    @(negedge clk);
    d_in = d;
    @(posedge clk);
    #1;
  endtask
  bit          m_have, m_locked, m_ep, m_rs;
  logic [31:0] m_prev, m_exp, m_bad;
  int          m_run, m_cnt;
  task automatic model_reset();
    m_have = 0; m_locked = 0; m_ep = 0; m_rs = 0;
    m_prev = 0; m_exp = 0; m_bad = 0; m_run = 0; m_cnt = 0;
  endtask
  task automatic model_step(input logic [31:0] d);
    m_ep = 0;
    m_rs = 0;
    if (!m_have) begin
      m_have = 1;
      m_prev = d;
      m_run = 0;
    end else if (!m_locked) begin
      if (d == m_prev + 32'd1) begin
        m_run++;
        if (m_run == 4) begin
          m_locked = 1;
          m_exp = d + 32'd1;
        end
      end else m_run = 0;
      m_prev = d;
    end else if (d == m_exp) begin
      m_prev = d;
      m_exp = d + 32'd1;
    end else begin
      if (d == 0) m_rs = 1;
      else begin
        m_ep = 1;
        m_bad = d;
        m_cnt = m_cnt < 65535 ? m_cnt + 1 : m_cnt;
      end
      m_locked = 0;
      m_run = 0;
      m_prev = d;
    end
  endtask
  initial begin
    logic [31:0] cur;
    int r;
    add(100, 0, 0, 0, 0, 0, 0);
    add(101, 0, 0, 0, 0, 0, 0);
    add(102, 0, 0, 0, 0, 0, 0);
    add(103, 0, 0, 0, 0, 0, 0);
    add(104, 1, 0, 0, 0, 0, 105);
    add(105, 1, 0, 0, 0, 0, 106);
    add(0,   0, 0, 1, 0, 0, 0);
    add(1,   0, 0, 0, 0, 0, 0);
    add(2,   0, 0, 0, 0, 0, 0);
    add(3,   0, 0, 0, 0, 0, 0);
    add(4,   1, 0, 0, 0, 0, 5);
    add(196, 0, 1, 0, 1, 196, 0);
    add(197, 0, 0, 0, 1, 196, 0);
    add(198, 0, 0, 0, 1, 196, 0);
    add(199, 0, 0, 0, 1, 196, 0);
    add(200, 1, 0, 0, 1, 196, 201);
    add(201, 1, 0, 0, 1, 196, 202);
    add(203, 0, 1, 0, 2, 203, 0);
    add(204, 0, 0, 0, 2, 203, 0);
    add(205, 0, 0, 0, 2, 203, 0);
    add(206, 0, 0, 0, 2, 203, 0);
    add(207, 1, 0, 0, 2, 203, 208);
    add(32'hFFFF_FFFB, 0, 1, 0, 3, 32'hFFFF_FFFB, 0);
    add(32'hFFFF_FFFC, 0, 0, 0, 3, 32'hFFFF_FFFB, 0);
    add(32'hFFFF_FFFD, 0, 0, 0, 3, 32'hFFFF_FFFB, 0);
    add(32'hFFFF_FFFE, 0, 0, 0, 3, 32'hFFFF_FFFB, 0);
    add(32'hFFFF_FFFF, 1, 0, 0, 3, 32'hFFFF_FFFB, 0);
    add(0,   1, 0, 0, 3, 32'hFFFF_FFFB, 1);
    add(1,   1, 0, 0, 3, 32'hFFFF_FFFB, 2);
    add(5,   0, 1, 0, 4, 5, 0);
    add(6,   0, 0, 0, 4, 5, 0);
    rst = 1'b0;
    d_in = 32'h1234;
    repeat (5) @(posedge clk);
    #1;
    check_all(0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    foreach (tbl[i]) begin
      step(tbl[i].d);
      check_all(tbl[i].l, tbl[i].ep, tbl[i].rs, tbl[i].cnt, tbl[i].bad, tbl[i].ex, tbl[i].l);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_all(0, 0, 0, 0, 0, 0, 1);
    chk("b_last_bad_rst", b_last_bad, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    cur = $urandom;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      cur = r < 80 ? cur + 32'd1 : r < 85 ? 32'd0 : r < 95 ? 32'($urandom) : 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
      step(cur);
      model_step(cur);
      check_all(m_locked, m_ep, m_rs, m_cnt, m_bad, m_exp, m_locked);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_all(0, 0, 0, 0, 0, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
